// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: PCSrc encodings, fetch FSM states,
// reset NOP word and the base opcodes also decoded by main_controller.
package riscv_pkg;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response port of the fetch unit.
// Handshake: imem_req rises with imem_addr valid and both hold steady until a
// cycle with imem_rvalid=1, in which imem_rdata is the word at imem_addr; that
// cycle may be the first cycle of the request. rvalid without req is ignored.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection; all arithmetic wraps mod 2^XLEN.
module next_pc_logic
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] PC,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  always_comb begin
    PCPlus4 = PC + XLEN'(4);
    target  = PCPlus4;
    case (PCSrc)
      PC_BRANCH: target = PC + ImmExt;
      PC_JALR:   target = ALUResult;
      default:   target = PCPlus4;
    endcase
    misaligned = (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, variable-latency fetch into the IR, next-PC application,
// sticky misaligned-target trap and retired-instruction counter.
module instr_fetch_unit #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              PCSrc,
  input  logic [XLEN-1:0]         ImmExt,
  input  logic [XLEN-1:0]         ALUResult,
  input  logic                    stall,
  instr_fetch_unit_if.master      imem,
  output logic [31:0]             instr,
  output logic [6:0]              opcode,
  output logic [2:0]              funct3,
  output logic [6:0]              funct7,
  output logic                    instr_valid,
  output logic [XLEN-1:0]         PC,
  output logic [XLEN-1:0]         PCPlus4,
  output logic                    fetch_fault,
  output logic [XLEN-1:0]         fault_addr,
  output logic [31:0]             instret,
  output riscv_pkg::fetch_state_e dbg_state
);
  import riscv_pkg::*;

  fetch_state_e    state, next_state;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            retire;

  next_pc_logic #(.XLEN(XLEN)) u_next_pc (
    .PC        (PC),
    .PCSrc     (PCSrc),
    .ImmExt    (ImmExt),
    .ALUResult (ALUResult),
    .PCPlus4   (PCPlus4),
    .target    (target),
    .misaligned(misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    instr_valid = 1'b0;
    retire      = 1'b0;
    case (state)
      ST_IDLE: next_state = ST_REQ;
      ST_REQ:  if (imem.imem_rvalid) next_state = ST_EXEC;
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire     = 1'b1;
          next_state = misaligned ? ST_FAULT : ST_REQ;
        end
      end
      default: next_state = ST_FAULT;
    endcase
  end

  // A faulting target is recorded but never loaded, so PC keeps the faulting instruction's address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC          <= RESET_PC;
      instr       <= NOP_INSTR;
      fetch_fault <= 1'b0;
      fault_addr  <= '0;
      instret     <= '0;
    end else begin
      if (state == ST_REQ && imem.imem_rvalid) instr <= imem.imem_rdata;
      if (retire) begin
        instret <= instret + 32'd1;
        if (misaligned) begin
          fetch_fault <= 1'b1;
          fault_addr  <= target;
        end else begin
          PC <= target;
        end
      end
    end
  end

  assign imem.imem_req  = (state == ST_REQ);
  assign imem.imem_addr = PC;
  assign opcode         = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[31:25];
  assign dbg_state      = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple latency-programmable memory.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        stall;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] instret;
  fetch_state_e dbg_state;

  int checks;
  int errors;

  // memory model controls
  logic        mem_en;
  int          mem_lat;
  int          wait_cnt;
  logic        force_rvalid;
  logic [31:0] mem_data;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCSrc      (PCSrc),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .stall      (stall),
    .imem       (bus.master),
    .instr      (instr),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .instr_valid(instr_valid),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .fetch_fault(fetch_fault),
    .fault_addr (fault_addr),
    .instret    (instret),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: answers after mem_lat wait cycles, word = mem_data + address
  assign bus.imem_rvalid = force_rvalid | (mem_en & bus.imem_req & (wait_cnt >= mem_lat));
  assign bus.imem_rdata  = mem_data + bus.imem_addr;

  always_ff @(posedge clk) begin
    if (!rst_n || !bus.imem_req || bus.imem_rvalid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; PCSrc = 2'b00; force_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", PC); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instr); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret got %h exp 0", instret); end
    checks++; if (fetch_fault !== 1'b0 || fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault got %b/%h exp 0/0", fetch_fault, fault_addr); end
    checks++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL reset_outputs got req=%b valid=%b exp 0/0", bus.imem_req, instr_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_i;
    mem_en = 1'b1; mem_lat = 0; mem_data = 32'h0050_0093;
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (instr_valid !== (k % 2 == 1) || bus.imem_req !== (k % 2 == 0)) begin
        errors++; $display("FAIL zw_pattern k=%0d got valid=%b req=%b exp %b/%b", k, instr_valid, bus.imem_req, (k % 2 == 1), (k % 2 == 0));
      end
      if (k % 2 == 0) begin
        checks++; if (bus.imem_addr !== 32'(4 * (k / 2))) begin errors++; $display("FAIL zw_addr k=%0d got %h exp %h", k, bus.imem_addr, 4 * (k / 2)); end
      end else begin
        exp_i = 32'h0050_0093 + 32'(4 * (k / 2));
        checks++; if (instr !== exp_i) begin errors++; $display("FAIL zw_instr k=%0d got %h exp %h", k, instr, exp_i); end
      end
      if (k == 1) begin
        checks++; if (opcode !== 7'h13 || funct3 !== 3'd0 || funct7 !== 7'd0) begin
          errors++; $display("FAIL zw_decode got %h/%h/%h exp 13/0/0", opcode, funct3, funct7);
        end
      end
    end
  endtask

  task automatic test_latency();
    mem_en = 1'b1; mem_lat = 1; mem_data = 32'h0000_0033;
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 2; w++) begin
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k) || instr_valid !== 1'b0) begin
          errors++; $display("FAIL lat_req k=%0d w=%0d got req=%b addr=%h valid=%b exp 1/%h/0", k, w, bus.imem_req, bus.imem_addr, instr_valid, 4 * k);
        end
      end
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h33 + 32'(4 * k)) begin
        errors++; $display("FAIL lat_exec k=%0d got valid=%b instr=%h exp 1/%h", k, instr_valid, instr, 32'h33 + 4 * k);
      end
    end
    @(negedge clk);
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL lat_instret got %0d exp 3", instret); end
  endtask

  task automatic test_branch_wrap();
    mem_en = 1'b1; mem_lat = 0; mem_data = 32'h0000_0063;
    reset_dut();
    @(negedge clk);
    @(negedge clk); PCSrc = PC_BRANCH; ImmExt = 32'h0000_0010;
    @(negedge clk); PCSrc = PC_PLUS4;
    checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL br_fwd got %h exp 00000010", bus.imem_addr); end
    @(negedge clk); PCSrc = PC_BRANCH; ImmExt = 32'hFFFF_FFF8;
    @(negedge clk); PCSrc = PC_PLUS4;
    checks++; if (bus.imem_addr !== 32'h08) begin errors++; $display("FAIL br_back got %h exp 00000008", bus.imem_addr); end
    @(negedge clk); PCSrc = PC_BRANCH; ImmExt = 32'hFFFF_FFF4;
    @(negedge clk); PCSrc = PC_PLUS4;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL br_neg got %h exp fffffffc", bus.imem_addr); end
    checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL pcplus4_wrap got %h exp 00000000", PCPlus4); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL pc_wrap got addr=%h req=%b exp 0/1", bus.imem_addr, bus.imem_req); end
  endtask

  task automatic test_fault();
    mem_en = 1'b1; mem_lat = 0; mem_data = 32'h0000_0067;
    reset_dut();
    @(negedge clk);
    @(negedge clk); PCSrc = PC_JALR; ALUResult = 32'h0000_0102;
    @(negedge clk); PCSrc = PC_PLUS4;
    checks++; if (fetch_fault !== 1'b1 || fault_addr !== 32'h102) begin errors++; $display("FAIL fault_flag got %b/%h exp 1/00000102", fetch_fault, fault_addr); end
    checks++; if (PC !== 32'h0 || dbg_state !== ST_FAULT) begin errors++; $display("FAIL fault_pc got pc=%h st=%0d exp 0/%0d", PC, dbg_state, ST_FAULT); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL fault_instret got %0d exp 1", instret); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1) begin
        errors++; $display("FAIL fault_hold k=%0d got req=%b valid=%b fault=%b exp 0/0/1", k, bus.imem_req, instr_valid, fetch_fault);
      end
    end
    reset_dut();
  endtask

  task automatic test_stall();
    mem_en = 1'b1; mem_lat = 0; mem_data = 32'h0000_0013;
    reset_dut();
    @(negedge clk);
    @(negedge clk); stall = 1'b1; PCSrc = PC_BRANCH; ImmExt = 32'h40;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (PC !== 32'h0 || instr !== 32'h13 || instret !== 32'd0 || instr_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold k=%0d got pc=%h instr=%h instret=%0d valid=%b exp 0/13/0/1", k, PC, instr, instret, instr_valid);
      end
      if (k == 0) begin PCSrc = PC_JALR; ALUResult = 32'h80; end
      if (k == 1) begin PCSrc = PC_BRANCH; ImmExt = 32'h40; end
      if (k == 2) begin stall = 1'b0; PCSrc = PC_JALR; ALUResult = 32'h20; end
    end
    @(negedge clk); PCSrc = PC_PLUS4;
    checks++; if (bus.imem_addr !== 32'h20 || instret !== 32'd1) begin errors++; $display("FAIL stall_release got addr=%h instret=%0d exp 00000020/1", bus.imem_addr, instret); end
  endtask

  task automatic test_reset_midreq();
    mem_en = 1'b1; mem_lat = 0; mem_data = 32'h0000_00B3;
    reset_dut();
    @(negedge clk);
    @(negedge clk); mem_en = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || instret !== 32'd1 || instr !== 32'hB3) begin
      errors++; $display("FAIL mid_pre got req=%b addr=%h instret=%0d instr=%h exp 1/4/1/b3", bus.imem_req, bus.imem_addr, instret, instr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE || PC !== 32'h0 || instr !== 32'h13 || instret !== 32'd0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset got st=%0d pc=%h instr=%h instret=%0d req=%b exp 0/0/13/0/0", dbg_state, PC, instr, instret, bus.imem_req);
    end
    rst_n = 1'b1; force_rvalid = 1'b1; mem_data = 32'hDEAD_BEEF;
    @(negedge clk); force_rvalid = 1'b0;
    checks++; if (dbg_state !== ST_REQ || instr !== 32'h13) begin errors++; $display("FAIL stray_rvalid got st=%0d instr=%h exp 1/00000013", dbg_state, instr); end
    @(negedge clk);
    checks++; if (dbg_state !== ST_REQ || bus.imem_req !== 1'b1 || instr !== 32'h13) begin
      errors++; $display("FAIL stray_wait got st=%0d req=%b instr=%h exp 1/1/13", dbg_state, bus.imem_req, instr);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; stall = 1'b0; PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;
    mem_en = 1'b0; mem_lat = 0; force_rvalid = 1'b0; mem_data = '0;
    test_zero_wait();
    test_latency();
    test_branch_wrap();
    test_fault();
    test_stall();
    test_reset_midreq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
